// File: rtl/norm2_pkg.sv
// Shared types for the norm2 accumulation engine.
// Holds the engine state enum, the accumulation mode enum and the drain length.
package norm2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_SQ  = 1'b0,
    MODE_ABS = 1'b1
  } mode_e;

  // DRAIN covers data, term and accumulate stages: counter values 0..2
  localparam int unsigned DRAIN_LAST = 2;

endpackage

// File: rtl/norm2_mem.sv
// Single-port RAM with registered read address (1-cycle read latency).
// Ports: clk; we/addr/wdata write port; rdata returns mem[addr] sampled on the previous edge.
// Contents are never reset.
module norm2_mem #(
  parameter int unsigned DATA_W = 27,
  parameter int unsigned DEPTH  = 1000,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic signed [DATA_W-1:0] wdata,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]        addr_q;

  // Write and read-address register
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    addr_q <= addr;
  end

  assign rdata = mem[addr_q];

endmodule

// File: rtl/norm2_pipe.sv
// Pipelined sum-of-squares / sum-of-absolute-values engine over an internal array.
// Ports: clk, rst (async active-high); r_enable + init_* start a run; controlArr* give an
// external agent the array (and stall the engine); w_enable/result/overflow report the run.
module norm2_pipe
  import norm2_pkg::*;
#(
  parameter int unsigned DATA_W = 27,
  parameter int unsigned DEPTH  = 1000,
  parameter int unsigned ACC_W  = 64,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     r_enable,
  input  logic [ADDR_W-1:0]        init_i,
  input  logic [ADDR_W:0]          init_end,
  input  logic signed [ACC_W-1:0]  init_acc,
  input  logic                     init_mode,
  input  logic                     controlArr,
  input  logic                     controlArrWEnable_a,
  input  logic [ADDR_W-1:0]        controlArrAddr_a,
  input  logic signed [DATA_W-1:0] controlArrWData_a,
  output logic signed [DATA_W-1:0] controlArrRData_a,
  output logic                     w_enable,
  output logic signed [ACC_W-1:0]  result,
  output logic                     overflow
);

  localparam int unsigned IDX_W  = ADDR_W + 1;
  localparam int unsigned PROD_W = 2 * DATA_W;

  if (ACC_W < PROD_W) begin : g_bad_acc_w
    $error("norm2_pipe: ACC_W must be at least 2*DATA_W");
  end

  state_e                    state, state_n;
  logic [IDX_W-1:0]          idx, idx_n, end_q;
  logic [1:0]                drain_cnt, drain_n;
  mode_e                     mode_q;
  logic                      issue_c;
  logic                      v1, v2;
  logic signed [PROD_W-1:0]  term_q, term_c, a_ext;
  logic signed [ACC_W-1:0]   acc, term_ext, sum_c;
  logic signed [DATA_W-1:0]  mem_rdata;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_we;

  // Array port mux: external agent owns the array while controlArr is high
  assign mem_addr = controlArr ? controlArrAddr_a : idx[ADDR_W-1:0];
  assign mem_we   = controlArr & controlArrWEnable_a;
  assign controlArrRData_a = controlArr ? mem_rdata : 'x;

  norm2_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (controlArrWData_a),
    .rdata (mem_rdata)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      drain_cnt <= '0;
      w_enable  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      drain_cnt <= drain_n;
      w_enable  <= (state_n == DONE);
    end
  end

  // Next state; a stall (controlArr) freezes index, drain counter and state
  always_comb begin
    state_n = state;
    idx_n   = idx;
    drain_n = drain_cnt;
    issue_c = 1'b0;
    if (r_enable) begin
      state_n = RUN;
      idx_n   = IDX_W'(init_i);
      drain_n = '0;
    end else begin
      case (state)
        RUN: begin
          if (!controlArr) begin
            if (idx < end_q) begin
              issue_c = 1'b1;
              idx_n   = idx + 1'b1;
            end else begin
              state_n = DRAIN;
              drain_n = '0;
            end
          end
        end
        DRAIN: begin
          if (!controlArr) begin
            if (drain_cnt == 2'(DRAIN_LAST)) state_n = DONE;
            else drain_n = drain_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Term: a*a or |a|, both computed in 2*DATA_W bits
  always_comb begin
    a_ext  = PROD_W'(mem_rdata);
    term_c = a_ext * a_ext;
    if (mode_q == MODE_ABS) term_c = a_ext[PROD_W-1] ? -a_ext : a_ext;
  end

  assign term_ext = ACC_W'(term_q);
  assign sum_c    = acc + term_ext;

  // Datapath: data-valid, term register and modulo accumulator with sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      end_q    <= '0;
      mode_q   <= MODE_SQ;
      v1       <= 1'b0;
      v2       <= 1'b0;
      term_q   <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else if (r_enable) begin
      end_q    <= init_end;
      mode_q   <= mode_e'(init_mode);
      v1       <= 1'b0;
      v2       <= 1'b0;
      acc      <= init_acc;
      overflow <= 1'b0;
    end else begin
      v1 <= issue_c;
      v2 <= v1;
      if (v1) term_q <= term_c;
      if (v2) begin
        acc <= sum_c;
        if ((acc[ACC_W-1] == term_ext[ACC_W-1]) && (sum_c[ACC_W-1] != acc[ACC_W-1]))
          overflow <= 1'b1;
      end
    end
  end

  assign result = acc;

endmodule

// File: tb/tb_norm2_pipe.sv
// Directed self-checking bench for norm2_pipe: default instance plus a 54-bit
// accumulator instance for the overflow case.
module tb_norm2_pipe;

  logic               clk = 1'b0;
  logic               rst;
  logic               r_enable;
  logic [9:0]         init_i;
  logic [10:0]        init_end;
  logic signed [63:0] init_acc;
  logic               init_mode;
  logic               controlArr;
  logic               ctl_we;
  logic [9:0]         ctl_addr;
  logic signed [26:0] ctl_wdata;
  logic signed [26:0] ctl_rdata;
  logic               w_enable;
  logic signed [63:0] result;
  logic               overflow;

  logic               o_r_enable;
  logic [9:0]         o_init_i;
  logic [10:0]        o_init_end;
  logic signed [53:0] o_init_acc;
  logic               o_init_mode;
  logic               o_controlArr;
  logic               o_we;
  logic [9:0]         o_addr;
  logic signed [26:0] o_wdata;
  logic signed [26:0] o_rdata;
  logic               o_w_enable;
  logic signed [53:0] o_result;
  logic               o_overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  norm2_pipe u_dut (
    .clk(clk), .rst(rst), .r_enable(r_enable), .init_i(init_i), .init_end(init_end),
    .init_acc(init_acc), .init_mode(init_mode), .controlArr(controlArr),
    .controlArrWEnable_a(ctl_we), .controlArrAddr_a(ctl_addr),
    .controlArrWData_a(ctl_wdata), .controlArrRData_a(ctl_rdata),
    .w_enable(w_enable), .result(result), .overflow(overflow)
  );

  norm2_pipe #(.DATA_W(27), .DEPTH(1000), .ACC_W(54)) u_ovf (
    .clk(clk), .rst(rst), .r_enable(o_r_enable), .init_i(o_init_i), .init_end(o_init_end),
    .init_acc(o_init_acc), .init_mode(o_init_mode), .controlArr(o_controlArr),
    .controlArrWEnable_a(o_we), .controlArrAddr_a(o_addr),
    .controlArrWData_a(o_wdata), .controlArrRData_a(o_rdata),
    .w_enable(o_w_enable), .result(o_result), .overflow(o_overflow)
  );

  task automatic start_run(input int i, input int e, input longint acc, input bit mode);
    @(negedge clk);
    init_i    = 10'(i);
    init_end  = 11'(e);
    init_acc  = 64'(acc);
    init_mode = mode;
    r_enable  = 1'b1;
    @(posedge clk);
    #1 r_enable = 1'b0;
  endtask

  // Counts edges after the r_enable edge until w_enable is seen; -1 on timeout
  task automatic wait_done(output int edges);
    int n;
    n = 0;
    edges = -1;
    while (n < 3000) begin
      @(posedge clk);
      #1 n++;
      if (w_enable) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    if (w_enable !== 1'b0) begin failures++; $display("FAIL reset_w_enable got=%b exp=0", w_enable); end
    checks++;
    if (result !== 64'sd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++;
  endtask

  task automatic test_load();
    controlArr = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      ctl_we    = 1'b1;
      ctl_addr  = 10'(k);
      ctl_wdata = 27'(k - 500);
    end
    @(negedge clk);
    ctl_we   = 1'b0;
    ctl_addr = 10'd5;
    @(posedge clk);
    #1;
    if (ctl_rdata !== -27'sd495) begin failures++; $display("FAIL ctl_readback got=%0d exp=-495", ctl_rdata); end
    checks++;
    @(negedge clk);
    controlArr = 1'b0;
  endtask

  task automatic test_sq_full();
    int e;
    start_run(0, 1000, 0, 1'b0);
    wait_done(e);
    if (e !== 1004) begin failures++; $display("FAIL sq_full_latency got=%0d exp=1004", e); end
    checks++;
    if (result !== 64'sd83333500) begin failures++; $display("FAIL sq_full_result got=%0d exp=83333500", result); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL sq_full_overflow got=%b exp=0", overflow); end
    checks++;
  endtask

  task automatic test_abs();
    int e;
    start_run(10, 20, 7, 1'b1);
    wait_done(e);
    if (e !== 14) begin failures++; $display("FAIL abs_latency got=%0d exp=14", e); end
    checks++;
    if (result !== 64'sd4862) begin failures++; $display("FAIL abs_result got=%0d exp=4862", result); end
    checks++;
  endtask

  task automatic test_empty();
    int e;
    start_run(5, 5, -3, 1'b0);
    wait_done(e);
    if (e !== 4) begin failures++; $display("FAIL empty_latency got=%0d exp=4", e); end
    checks++;
    if (result !== -64'sd3) begin failures++; $display("FAIL empty_result got=%0d exp=-3", result); end
    checks++;
    // init_i > init_end issues nothing either
    start_run(7, 3, 42, 1'b1);
    wait_done(e);
    if (e !== 4) begin failures++; $display("FAIL reversed_latency got=%0d exp=4", e); end
    checks++;
    if (result !== 64'sd42) begin failures++; $display("FAIL reversed_result got=%0d exp=42", result); end
    checks++;
  endtask

  // a = -2,-1,0,1,2 -> squares sum 10, plus 100; result must then hold in DONE
  task automatic test_sq_small(input string tag);
    int e;
    start_run(498, 503, 100, 1'b0);
    wait_done(e);
    if (e !== 9) begin failures++; $display("FAIL %s_latency got=%0d exp=9", tag, e); end
    checks++;
    if (result !== 64'sd110) begin failures++; $display("FAIL %s_result got=%0d exp=110", tag, result); end
    checks++;
    repeat (5) @(posedge clk);
    #1;
    if (w_enable !== 1'b1 || result !== 64'sd110) begin
      failures++; $display("FAIL %s_hold got w=%b r=%0d exp w=1 r=110", tag, w_enable, result);
    end
    checks++;
  endtask

  task automatic test_stall();
    int e;
    start_run(0, 1000, 0, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    controlArr = 1'b1;
    ctl_addr   = 10'd3;
    @(posedge clk);
    #1;
    if (ctl_rdata !== -27'sd497) begin failures++; $display("FAIL stall_read got=%0d exp=-497", ctl_rdata); end
    checks++;
    repeat (4) @(posedge clk);
    #1 controlArr = 1'b0;
    wait_done(e);
    if (e >= 0) e = e + 105;
    if (e !== 1009) begin failures++; $display("FAIL stall_latency got=%0d exp=1009", e); end
    checks++;
    if (result !== 64'sd83333500) begin failures++; $display("FAIL stall_result got=%0d exp=83333500", result); end
    checks++;
  endtask

  task automatic test_restart();
    int e;
    start_run(0, 1000, 0, 1'b0);
    repeat (100) @(posedge clk);
    start_run(10, 20, 7, 1'b1);
    wait_done(e);
    if (e !== 14) begin failures++; $display("FAIL restart_latency got=%0d exp=14", e); end
    checks++;
    if (result !== 64'sd4862) begin failures++; $display("FAIL restart_result got=%0d exp=4862", result); end
    checks++;
  endtask

  task automatic test_async_reset();
    start_run(0, 1000, 0, 1'b0);
    repeat (50) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    if (result !== 64'sd0 || w_enable !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got r=%0d w=%b o=%b exp all 0", result, w_enable, overflow);
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_overflow();
    int n;
    logic signed [26:0] v;
    v = 27'h4000000;
    o_controlArr = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      o_we    = 1'b1;
      o_addr  = 10'(k);
      o_wdata = v;
    end
    @(negedge clk);
    o_we         = 1'b0;
    o_controlArr = 1'b0;
    o_init_i     = 10'd0;
    o_init_end   = 11'd1000;
    o_init_acc   = 54'sd0;
    o_init_mode  = 1'b0;
    o_r_enable   = 1'b1;
    @(posedge clk);
    #1 o_r_enable = 1'b0;
    n = 0;
    while (n < 1100 && !o_w_enable) begin
      @(posedge clk);
      #1 n++;
    end
    if (n !== 1004) begin failures++; $display("FAIL ovf_latency got=%0d exp=1004", n); end
    checks++;
    if (o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", o_overflow); end
    checks++;
    if (o_result !== 54'sd0) begin failures++; $display("FAIL ovf_result got=%0d exp=0", o_result); end
    checks++;
  endtask

  initial begin
    rst = 1'b1;
    r_enable = 1'b0; init_i = '0; init_end = '0; init_acc = '0; init_mode = 1'b0;
    controlArr = 1'b0; ctl_we = 1'b0; ctl_addr = '0; ctl_wdata = '0;
    o_r_enable = 1'b0; o_init_i = '0; o_init_end = '0; o_init_acc = '0; o_init_mode = 1'b0;
    o_controlArr = 1'b0; o_we = 1'b0; o_addr = '0; o_wdata = '0;
    repeat (3) @(posedge clk);
    #1 test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_load();
    test_sq_full();
    test_abs();
    test_empty();
    test_sq_small("sq_small");
    test_stall();
    test_restart();
    test_async_reset();
    test_sq_small("after_reset");
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
